imem_arbiter: RTL and testbench
===============================

Name: imem_arbiter

Overview:
Two-port arbiter that shares the single combinational instruction-ROM read port (addr in, rdata out, zero latency) between the CPU instruction-fetch stage (port IF) and the debug/monitor read port (port DBG).
- Grants at most one read per cycle, round-robin when both ports request.
- Registers the ROM output per port and returns it one cycle after grant with a valid pulse.
- Supports a debug halt that masks fetch.
- Sits between the fetch stage / debug unit and the instruction ROM.

Parameters:
DATA_WIDTH, 32, ROM word width and rdata width.
BUS_WIDTH, 10, ROM word-address width (ROM depth 2**BUS_WIDTH).

Ports:
clk  input  1  system clock, all state on rising edge.
rst  input  1  synchronous active-high reset.
if_req  input  1  fetch read request, level; held with if_addr stable until if_gnt.
if_addr  input  BUS_WIDTH  fetch word address.
if_gnt  output  1  fetch request accepted this cycle (combinational).
if_rvalid  output  1  one-cycle pulse; if_rdata valid.
if_rdata  output  DATA_WIDTH  registered fetch read data.
dbg_req  input  1  debug read request, level; same rules as if_req.
dbg_addr  input  BUS_WIDTH  debug word address.
dbg_halt  input  1  masks IF requests while high.
dbg_gnt  output  1  debug request accepted this cycle (combinational).
dbg_rvalid  output  1  one-cycle pulse; dbg_rdata valid.
dbg_rdata  output  DATA_WIDTH  registered debug read data.
mem_addr  output  BUS_WIDTH  address driven to ROM.
mem_rdata  input  DATA_WIDTH  ROM read data (combinational in mem_addr).

Behaviour:
- Reset (rst=1 at edge):
  - if_rvalid, dbg_rvalid, if_rdata, dbg_rdata clear to 0.
  - last_gnt pointer set to DBG, so IF wins the first contention.
  - While rst=1, if_gnt=dbg_gnt=0.
- Effective requests:
  - if_eff = if_req & ~dbg_halt.
  - dbg_eff = dbg_req.
- Grant, combinational, at most one per cycle:
  - Only if_eff: if_gnt=1.
  - Only dbg_eff: dbg_gnt=1.
  - Both: grant the port not equal to last_gnt.
  - Neither: no grant.
- last_gnt updates to the granted port on any grant edge; it holds when there is no grant.
- mem_addr:
  - dbg_addr when dbg_gnt=1.
  - Otherwise if_addr (including idle), so a fetch address is always presented.
- Response, latency 1:
  - On the edge ending a cycle with X_gnt=1, X_rdata <= mem_rdata and X_rvalid <= 1.
  - X_rvalid <= 0 on any edge without X_gnt.
  - X_rdata holds its last value until the next grant to X.
- Back-to-back: one port may be granted every cycle.
  - Rdata for consecutive grants appears on consecutive cycles, in grant order.
- Fairness: with both ports requesting continuously (dbg_halt=0), grants alternate IF, DBG, IF, DBG...
  - Worst-case wait for either port is 1 cycle.
- dbg_halt:
  - Rising mid-stream: an IF grant in the same cycle is suppressed; the IF response already in flight still delivers its rvalid next cycle.
  - While high, if_gnt=0 regardless of if_req; fetch stalls with if_req held.
- Requester rules:
  - Addr must be stable while req=1 and gnt=0. Changing it is a requester error; the arbiter samples whatever addr is present in the grant cycle.
  - Dropping req before gnt is allowed: the request is withdrawn and no rvalid is produced.
- Addresses are word addresses and wrap naturally in BUS_WIDTH bits; there is no range check.
- Reset mid-operation:
  - A grant in the cycle before rst produces no rvalid on the reset edge; rst takes precedence.
  - Pending requests are re-arbitrated after rst drops, IF first.
- Implementation: a 1-bit last_gnt state plus two per-port response registers; no other state.

Test Plan:
1. Reset, ROM[5]=0x2402000A, if_req=1, if_addr=5 after rst drops -> if_gnt=1 in cycle 0; if_rvalid=1 with if_rdata=0x2402000A in cycle 1; dbg outputs stay 0.
2. Both requesting continuously from reset release, if_addr=1, dbg_addr=2, ROM[1]=0x11, ROM[2]=0x22 -> grants IF,DBG,IF,DBG; if_rvalid on cycles 1,3,5; dbg_rvalid on cycles 2,4,6; rdata 0x11/0x22 respectively; mem_addr alternates 1,2.
3. dbg_halt=1 with if_req=1, dbg_req=0 for 4 cycles -> if_gnt=0, if_rvalid=0 throughout; dbg_halt drops -> if_gnt same cycle, rvalid next cycle.
4. IF streams addresses 0,1,2,3 on consecutive grants -> if_rvalid high 4 consecutive cycles with ROM[0..3] in order; if_rdata holds ROM[3] afterward with if_rvalid=0.
5. Grant to DBG at addr 7, rst asserted next cycle -> dbg_rvalid=0, dbg_rdata=0 after reset edge; with both req held after release, IF is granted first.
6. if_addr=2**BUS_WIDTH-1 (1023) -> mem_addr=1023, if_rdata=ROM[1023]; dbg_req withdrawn before grant while IF holds the port -> no dbg_rvalid.

Source files
------------

// File: rtl/imem_arbiter.sv
// Round-robin arbiter sharing one combinational instruction-ROM read port
// between the fetch stage (IF) and the debug unit (DBG), with registered responses.
module imem_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int BUS_WIDTH  = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req,
  input  logic [BUS_WIDTH-1:0]  if_addr,
  output logic                  if_gnt,
  output logic                  if_rvalid,
  output logic [DATA_WIDTH-1:0] if_rdata,
  input  logic                  dbg_req,
  input  logic [BUS_WIDTH-1:0]  dbg_addr,
  input  logic                  dbg_halt,
  output logic                  dbg_gnt,
  output logic                  dbg_rvalid,
  output logic [DATA_WIDTH-1:0] dbg_rdata,
  output logic [BUS_WIDTH-1:0]  mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  typedef enum logic {
    GNT_IF  = 1'b0,
    GNT_DBG = 1'b1
  } port_e;

  port_e                 last_q, last_d;
  logic                  if_eff, dbg_eff;
  logic                  if_rvalid_q, dbg_rvalid_q;
  logic [DATA_WIDTH-1:0] if_rdata_q, dbg_rdata_q;

  assign if_eff  = if_req & ~dbg_halt;
  assign dbg_eff = dbg_req;

  always_comb begin
    if_gnt  = 1'b0;
    dbg_gnt = 1'b0;
    last_d  = last_q;
    if (!rst) begin
      if (if_eff && dbg_eff) begin
        // On contention the port that did not win last time gets the ROM.
        if (last_q == GNT_DBG) if_gnt  = 1'b1;
        else                   dbg_gnt = 1'b1;
      end else if (if_eff) begin
        if_gnt = 1'b1;
      end else if (dbg_eff) begin
        dbg_gnt = 1'b1;
      end
    end
    if (if_gnt)       last_d = GNT_IF;
    else if (dbg_gnt) last_d = GNT_DBG;
  end

  // The fetch address is presented whenever debug does not own the port.
  assign mem_addr = dbg_gnt ? dbg_addr : if_addr;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q       <= GNT_DBG;
      if_rvalid_q  <= 1'b0;
      dbg_rvalid_q <= 1'b0;
      if_rdata_q   <= '0;
      dbg_rdata_q  <= '0;
    end else begin
      last_q       <= last_d;
      if_rvalid_q  <= if_gnt;
      dbg_rvalid_q <= dbg_gnt;
      if (if_gnt)  if_rdata_q  <= mem_rdata;
      if (dbg_gnt) dbg_rdata_q <= mem_rdata;
    end
  end

  assign if_rvalid  = if_rvalid_q;
  assign if_rdata   = if_rdata_q;
  assign dbg_rvalid = dbg_rvalid_q;
  assign dbg_rdata  = dbg_rdata_q;

endmodule

// File: tb/tb_imem_arbiter.sv
// Scoreboard bench for imem_arbiter: directed grant vectors push expected
// read data; a monitor checks each port's rvalid/rdata on the due cycle.
module tb_imem_arbiter;

  localparam int DW = 32;
  localparam int BW = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          if_req = 1'b0, dbg_req = 1'b0, dbg_halt = 1'b0;
  logic [BW-1:0] if_addr = '0, dbg_addr = '0;
  logic          if_gnt, dbg_gnt, if_rvalid, dbg_rvalid;
  logic [DW-1:0] if_rdata, dbg_rdata, mem_rdata;
  logic [BW-1:0] mem_addr;

  logic [DW-1:0] rom [1024];
  assign mem_rdata = rom[mem_addr];

  imem_arbiter #(.DATA_WIDTH(DW), .BUS_WIDTH(BW)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_halt(dbg_halt),
    .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [31:0] data;
  } exp_t;

  exp_t if_q[$];
  exp_t dbg_q[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One arbitration cycle: drive inputs, check the combinational grant,
  // and queue the read data that must come back on the following cycle.
  task automatic step(input logic r, input logic ir, input logic [BW-1:0] ia,
                      input logic dr, input logic [BW-1:0] da, input logic h,
                      input logic eig, input logic edg, input logic [BW-1:0] ema);
    exp_t e;
    @(negedge clk);
    rst = r; if_req = ir; if_addr = ia; dbg_req = dr; dbg_addr = da; dbg_halt = h;
    #1;
    check("if_gnt", {31'b0, if_gnt}, {31'b0, eig});
    check("dbg_gnt", {31'b0, dbg_gnt}, {31'b0, edg});
    check("mem_addr", {22'b0, mem_addr}, {22'b0, ema});
    e.due  = cyc + 1;
    e.data = rom[ema];
    if (eig) if_q.push_back(e);
    if (edg) dbg_q.push_back(e);
    @(posedge clk);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (if_q.size() > 0 && if_q[0].due == cyc) begin
        check("if_rvalid", {31'b0, if_rvalid}, 32'd1);
        check("if_rdata", if_rdata, if_q[0].data);
        void'(if_q.pop_front());
      end else begin
        check("if_rvalid_idle", {31'b0, if_rvalid}, 32'd0);
      end
      if (dbg_q.size() > 0 && dbg_q[0].due == cyc) begin
        check("dbg_rvalid", {31'b0, dbg_rvalid}, 32'd1);
        check("dbg_rdata", dbg_rdata, dbg_q[0].data);
        void'(dbg_q.pop_front());
      end else begin
        check("dbg_rvalid_idle", {31'b0, dbg_rvalid}, 32'd0);
      end
    end
  end

  initial begin
    for (int i = 0; i < 1024; i++) rom[i] = 32'h5A5A0000 ^ (i * 32'h00010001);
    rom[1]    = 32'h00000011;
    rom[2]    = 32'h00000022;
    rom[5]    = 32'h2402000A;
    rom[1023] = 32'hDEADBEEF;

    // Reset holds grants low even with both ports requesting.
    step(1, 1, 5, 1, 6, 0, 0, 0, 5);
    step(1, 1, 5, 1, 6, 0, 0, 0, 5);
    #2;
    check("rst_if_rvalid", {31'b0, if_rvalid}, 32'd0);
    check("rst_dbg_rvalid", {31'b0, dbg_rvalid}, 32'd0);
    check("rst_if_rdata", if_rdata, 32'd0);
    check("rst_dbg_rdata", dbg_rdata, 32'd0);

    // Single fetch after reset.
    step(0, 1, 5, 0, 0, 0, 1, 0, 5);
    step(0, 0, 5, 0, 0, 0, 0, 0, 5);
    step(0, 0, 5, 0, 0, 0, 0, 0, 5);

    // Continuous contention from reset release alternates IF first.
    step(1, 1, 1, 1, 2, 0, 0, 0, 1);
    step(0, 1, 1, 1, 2, 0, 1, 0, 1);
    step(0, 1, 1, 1, 2, 0, 0, 1, 2);
    step(0, 1, 1, 1, 2, 0, 1, 0, 1);
    step(0, 1, 1, 1, 2, 0, 0, 1, 2);
    step(0, 1, 1, 1, 2, 0, 1, 0, 1);
    step(0, 1, 1, 1, 2, 0, 0, 1, 2);
    step(0, 0, 1, 0, 2, 0, 0, 0, 1);

    // Halt rises mid-stream: in-flight fetch still returns, new fetch stalls.
    step(0, 1, 3, 0, 0, 0, 1, 0, 3);
    for (int k = 0; k < 4; k++) step(0, 1, 3, 0, 0, 1, 0, 0, 3);
    step(0, 1, 3, 0, 0, 0, 1, 0, 3);
    step(0, 0, 3, 0, 0, 0, 0, 0, 3);

    // Back-to-back fetch stream, then rdata holds.
    for (int a = 0; a < 4; a++) step(0, 1, BW'(a), 0, 0, 0, 1, 0, BW'(a));
    step(0, 0, 3, 0, 0, 0, 0, 0, 3);
    step(0, 0, 3, 0, 0, 0, 0, 0, 3);
    #2;
    check("if_rdata_hold", if_rdata, rom[3]);
    check("if_rvalid_hold", {31'b0, if_rvalid}, 32'd0);

    // Debug grant, then reset: response cleared, IF wins after release.
    step(0, 0, 3, 1, 7, 0, 0, 1, 7);
    step(1, 1, 4, 1, 7, 0, 0, 0, 4);
    #2;
    check("rst_mid_dbg_rvalid", {31'b0, dbg_rvalid}, 32'd0);
    check("rst_mid_dbg_rdata", dbg_rdata, 32'd0);
    step(0, 1, 4, 1, 7, 0, 1, 0, 4);
    step(0, 0, 4, 0, 7, 0, 0, 0, 4);

    // Top address, and a debug request withdrawn while IF holds the port.
    step(0, 0, 4, 1, 9, 0, 0, 1, 9);
    step(0, 1, 1023, 1, 9, 0, 1, 0, 1023);
    step(0, 0, 1023, 0, 9, 0, 0, 0, 1023);
    step(0, 0, 1023, 0, 9, 0, 0, 0, 1023);
    step(0, 0, 1023, 0, 9, 0, 0, 0, 1023);

    check("if_q_drained", if_q.size(), 32'd0);
    check("dbg_q_drained", dbg_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
